// File: rtl/tcm_port_arb_if.sv
// -----------------------------------------------------------------------------
// tcm_port_arb_if
// One requester port of the TCM arbiter. The same bundle is used for the CPU
// data port and the external AXI-to-TCM path.
//
//   rd       requester -> arbiter  read request
//   wr[4]    requester -> arbiter  byte write strobes (nonzero = write)
//   addr[32] requester -> arbiter  byte address
//   data_wr  requester -> arbiter  write data
//   accept   arbiter -> requester  request granted this cycle (combinational)
//   ack      arbiter -> requester  access complete (registered, one cycle later)
//   data_rd  arbiter -> requester  read data, valid with ack
//
// modport master : requester side
// modport slave  : arbiter side
// -----------------------------------------------------------------------------
interface tcm_port_arb_if;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        accept;
    logic        ack;
    logic [31:0] data_rd;

    modport master (
        output rd, wr, addr, data_wr,
        input  accept, ack, data_rd
    );

    modport slave (
        input  rd, wr, addr, data_wr,
        output accept, ack, data_rd
    );
endinterface

// File: rtl/tcm_port_arb.sv
// -----------------------------------------------------------------------------
// tcm_port_arb
// Shares the single-ported TCM RAM between the CPU data port (requester 0) and
// the external AXI-to-TCM path (requester 1). At most one access is granted per
// cycle; the acknowledge and read data come back one cycle later. A saturating
// counter of CPU cycles lost to contention is exported for telemetry.
//
// Parameters
//   RAM_AW        RAM word-address width (depth = 2^RAM_AW words of 32 bits)
//   STARVE_LIMIT  consecutive denied EXT cycles before EXT is forced (1..255)
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   cpu, ext            requester ports (tcm_port_arb_if.slave)
//   ram_en_o            RAM enable
//   ram_wr_o[4]         RAM byte write enables
//   ram_addr_o[RAM_AW]  RAM word address
//   ram_data_o[32]      RAM write data
//   ram_data_i[32]      RAM read data, one cycle after ram_en_o
//   cpu_stall_cnt_o[32] saturating count of cycles the CPU was denied
//
// Build option
//   TCM_ARB_STARVE_GUARD_EN  when defined, a starvation counter forces an EXT
//                            win after STARVE_LIMIT denied cycles. Otherwise
//                            arbitration is strict CPU priority.
// -----------------------------------------------------------------------------
module tcm_port_arb #(
    parameter int RAM_AW       = 14,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tcm_port_arb_if.slave     cpu,
    tcm_port_arb_if.slave     ext,
    output logic              ram_en_o,
    output logic [3:0]        ram_wr_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       cpu_stall_cnt_o
);

    // Owner of the access sitting in the response register.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } rsp_t;

    // -------------------------------------------------------------------------
    // Request decode and grant
    // -------------------------------------------------------------------------
    logic cpu_act;
    logic ext_act;
    logic force_ext;
    logic cpu_win;
    logic ext_win;

    assign cpu_act = cpu.rd | (|cpu.wr);
    assign ext_act = ext.rd | (|ext.wr);

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        ext_win = 1'b0;
        cpu_win = 1'b0;
        if (!rst_i) begin
            ext_win = ext_act & (~cpu_act | force_ext);
            cpu_win = cpu_act & ~ext_win;
        end
    end

    assign cpu.accept = cpu_win;
    assign ext.accept = ext_win;

    // -------------------------------------------------------------------------
    // RAM drive for the winner. A write strobe overrides a simultaneous rd,
    // which falls out naturally since the strobes are passed straight through.
    // -------------------------------------------------------------------------
    always_comb begin
        ram_en_o   = 1'b0;
        ram_wr_o   = 4'h0;
        ram_addr_o = '0;
        ram_data_o = 32'h0;
        if (cpu_win) begin
            ram_en_o   = 1'b1;
            ram_wr_o   = cpu.wr;
            ram_addr_o = cpu.addr[RAM_AW+1:2];
            ram_data_o = cpu.data_wr;
        end else if (ext_win) begin
            ram_en_o   = 1'b1;
            ram_wr_o   = ext.wr;
            ram_addr_o = ext.addr[RAM_AW+1:2];
            ram_data_o = ext.data_wr;
        end
    end

    // Upper address bits alias; byte offset is implied by the strobes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu.addr[31:RAM_AW+2], cpu.addr[1:0],
                                ext.addr[31:RAM_AW+2], ext.addr[1:0]};

    // -------------------------------------------------------------------------
    // Response register and read-data return
    // -------------------------------------------------------------------------
    rsp_t        rsp_q, rsp_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] ext_rdata_q, ext_rdata_d;
    logic        cpu_ack;
    logic        ext_ack;

    always_comb begin
        rsp_d.vld = cpu_win | ext_win;
        rsp_d.own = ext_win ? OWN_EXT : OWN_CPU;
    end

    // Ack is masked during reset so an access accepted just before reset is
    // dropped rather than acknowledged in the reset cycle.
    assign cpu_ack = rsp_q.vld & (rsp_q.own == OWN_CPU) & ~rst_i;
    assign ext_ack = rsp_q.vld & (rsp_q.own == OWN_EXT) & ~rst_i;

    // RAM read data flows straight through on the ack cycle; the non-owner
    // keeps showing whatever it was last given.
    assign cpu_rdata_d = cpu_ack ? ram_data_i : cpu_rdata_q;
    assign ext_rdata_d = ext_ack ? ram_data_i : ext_rdata_q;

    assign cpu.ack     = cpu_ack;
    assign ext.ack     = ext_ack;
    assign cpu.data_rd = cpu_rdata_d;
    assign ext.data_rd = ext_rdata_d;

    // -------------------------------------------------------------------------
    // CPU contention counter (saturating)
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_act && !cpu_win && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    assign cpu_stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q       <= '{vld: 1'b0, own: OWN_CPU};
            cpu_rdata_q <= 32'h0;
            ext_rdata_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            rsp_q       <= rsp_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // EXT starvation guard
    // -------------------------------------------------------------------------
`ifdef TCM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       force_ext_q, force_ext_d;

    // force_ext is armed on the denied cycle where the count hits LIMIT-1, so
    // under continuous contention EXT wins in cycle LIMIT of its wait.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        force_ext_d  = force_ext_q;
        if (ext_win) begin
            starve_cnt_d = 8'h0;
            force_ext_d  = 1'b0;
        end else if (ext_act) begin
            if (starve_cnt_q != 8'hFF)
                starve_cnt_d = starve_cnt_q + 8'd1;
            if (starve_cnt_q == STARVE_LAST)
                force_ext_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= 8'h0;
            force_ext_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            force_ext_q  <= force_ext_d;
        end
    end

    assign force_ext = force_ext_q;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^8'(STARVE_LIMIT);
    assign force_ext = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_port_arb.sv
module tb_tcm_port_arb;
    localparam int RAM_AW = 14;
    localparam int L      = 4;
`ifdef TCM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
    localparam int NC    = 40;
`else
    localparam bit GUARD = 1'b0;
    localparam int NC    = 100;
`endif

    logic              clk;
    logic              rst;
    logic              ram_en;
    logic [3:0]        ram_wr;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       stall_cnt;

    tcm_port_arb_if cpu_if ();
    tcm_port_arb_if ext_if ();

    tcm_port_arb #(.RAM_AW(RAM_AW), .STARVE_LIMIT(L)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu            (cpu_if),
        .ext            (ext_if),
        .ram_en_o       (ram_en),
        .ram_wr_o       (ram_wr),
        .ram_addr_o     (ram_addr),
        .ram_data_o     (ram_wdata),
        .ram_data_i     (ram_rdata),
        .cpu_stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-first, one-cycle read latency.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic crd, input logic [3:0] cwr, input logic [31:0] caddr,
                          input logic [31:0] cdat, input logic erd, input logic [3:0] ewr,
                          input logic [31:0] eaddr, input logic [31:0] edat);
        cpu_if.rd = crd; cpu_if.wr = cwr; cpu_if.addr = caddr; cpu_if.data_wr = cdat;
        ext_if.rd = erd; ext_if.wr = ewr; ext_if.addr = eaddr; ext_if.data_wr = edat;
    endtask

    task automatic idle();
        set_in(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cpu_accept"}, 32'(cpu_if.accept), 32'h0);
        chk({tag, " ext_accept"}, 32'(ext_if.accept), 32'h0);
        chk({tag, " cpu_ack"},    32'(cpu_if.ack),    32'h0);
        chk({tag, " ext_ack"},    32'(ext_if.ack),    32'h0);
        chk({tag, " ram_en"},     32'(ram_en),        32'h0);
        chk({tag, " ram_wr"},     32'(ram_wr),        32'h0);
        chk({tag, " ram_addr"},   32'(ram_addr),      32'h0);
        chk({tag, " ram_data"},   ram_wdata,          32'h0);
        chk({tag, " cpu_rdata"},  cpu_if.data_rd,     32'h0);
        chk({tag, " ext_rdata"},  ext_if.data_rd,     32'h0);
        chk({tag, " stall_cnt"},  stall_cnt,          32'h0);
    endtask

    typedef struct {
        logic        crd;  logic [3:0] cwr; logic [31:0] caddr; logic [31:0] cdat;
        logic        erd;  logic [3:0] ewr; logic [31:0] eaddr; logic [31:0] edat;
        logic        cacc; logic eacc; logic cack; logic eack;
        logic        cchk; logic [31:0] cdrd; logic echk; logic [31:0] edrd;
        logic        en;   logic [3:0] rwr; logic [13:0] raddr;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    initial begin
        // Inputs: cpu rd,wr,addr,data | ext rd,wr,addr,data
        // Expect: cacc,eacc,cack,eack | cchk,cdata,echk,edata | ram en,wr,addr
        vec[0]  = '{1'b0,4'hF,32'h80,32'hDEADBEEF, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'hF,14'h20};
        vec[1]  = '{1'b1,4'h0,32'h80,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'h0,14'h20};
        vec[2]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,1'b1,1'b0, 1'b1,32'hDEADBEEF,1'b1,32'h0, 1'b0,4'h0,14'h0};
        vec[3]  = '{1'b0,4'hF,32'h84,32'h11223344, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b0,1'b0, 1'b1,32'hDEADBEEF,1'b0,32'h0, 1'b1,4'hF,14'h21};
        vec[4]  = '{1'b0,4'h1,32'h84,32'h000000AA, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'h1,14'h21};
        vec[5]  = '{1'b1,4'h0,32'h84,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'h0,14'h21};
        vec[6]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,1'b1,1'b0, 1'b1,32'h112233AA,1'b0,32'h0, 1'b0,4'h0,14'h0};
        vec[7]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,1'b0,1'b0, 1'b1,32'h112233AA,1'b0,32'h0, 1'b0,4'h0,14'h0};
        vec[8]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'hF,32'h0001_0000,32'hCAFEF00D,
                    1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'hF,14'h0};
        vec[9]  = '{1'b0,4'h0,32'h0,32'h0, 1'b1,4'h0,32'h0,32'h0,
                    1'b0,1'b1,1'b0,1'b1, 1'b1,32'h112233AA,1'b0,32'h0, 1'b1,4'h0,14'h0};
        vec[10] = '{1'b1,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b0,1'b1, 1'b0,32'h0,1'b1,32'hCAFEF00D, 1'b1,4'h0,14'h0};
        vec[11] = '{1'b1,4'h0,32'h80,32'h0, 1'b1,4'h0,32'h84,32'h0,
                    1'b1,1'b0,1'b1,1'b0, 1'b1,32'hCAFEF00D,1'b1,32'hCAFEF00D, 1'b1,4'h0,14'h20};
        vec[12] = '{1'b0,4'h0,32'h0,32'h0, 1'b1,4'h0,32'h84,32'h0,
                    1'b0,1'b1,1'b1,1'b0, 1'b1,32'hDEADBEEF,1'b0,32'h0, 1'b1,4'h0,14'h21};
        vec[13] = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,1'b0,1'b1, 1'b0,32'h0,1'b1,32'h112233AA, 1'b0,4'h0,14'h0};
        vec[14] = '{1'b1,4'h2,32'h80,32'h00005500, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'h2,14'h20};
        vec[15] = '{1'b1,4'h0,32'h80,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b1,4'h0,14'h20};
        vec[16] = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,1'b1,1'b0, 1'b1,32'hDEAD55EF,1'b0,32'h0, 1'b0,4'h0,14'h0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle();
        step(); step(); step();
        rst = 1'b0;
        #4;
        chk_all_zero("reset");
        step();

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            set_in(vec[i].crd, vec[i].cwr, vec[i].caddr, vec[i].cdat,
                   vec[i].erd, vec[i].ewr, vec[i].eaddr, vec[i].edat);
            #4;
            chk($sformatf("v%0d cpu_accept", i), 32'(cpu_if.accept), 32'(vec[i].cacc));
            chk($sformatf("v%0d ext_accept", i), 32'(ext_if.accept), 32'(vec[i].eacc));
            chk($sformatf("v%0d cpu_ack", i),    32'(cpu_if.ack),    32'(vec[i].cack));
            chk($sformatf("v%0d ext_ack", i),    32'(ext_if.ack),    32'(vec[i].eack));
            chk($sformatf("v%0d ram_en", i),     32'(ram_en),        32'(vec[i].en));
            chk($sformatf("v%0d ram_wr", i),     32'(ram_wr),        32'(vec[i].rwr));
            if (vec[i].en) chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vec[i].raddr));
            if (vec[i].cchk) chk($sformatf("v%0d cpu_rdata", i), cpu_if.data_rd, vec[i].cdrd);
            if (vec[i].echk) chk($sformatf("v%0d ext_rdata", i), ext_if.data_rd, vec[i].edrd);
            chk($sformatf("v%0d stall_cnt", i), stall_cnt, 32'h0);
            step();
        end

        // ---------------- continuous contention ----------------
        do_reset();
        begin
            int  grants;
            bit  prev_c;
            bit  prev_e;
            grants = 0;
            prev_c = 1'b0;
            prev_e = 1'b0;
            for (int c = 0; c < NC; c++) begin
                bit exp_e;
                exp_e = GUARD && ((c % (L + 1)) == L);
                set_in(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
                #4;
                chk($sformatf("cont c%0d ext_accept", c), 32'(ext_if.accept), 32'(exp_e));
                chk($sformatf("cont c%0d cpu_accept", c), 32'(cpu_if.accept), 32'(!exp_e));
                chk($sformatf("cont c%0d cpu_ack", c),    32'(cpu_if.ack),    32'(prev_c));
                chk($sformatf("cont c%0d ext_ack", c),    32'(ext_if.ack),    32'(prev_e));
                chk($sformatf("cont c%0d stall_cnt", c),  stall_cnt,          32'(grants));
                prev_c = !exp_e;
                prev_e = exp_e;
                if (exp_e) grants++;
                step();
            end
            idle();
            #4;
            chk("cont final stall_cnt", stall_cnt, GUARD ? 32'(NC / (L + 1)) : 32'h0);
            step();
        end

        // ---------------- reset during pending ack ----------------
        set_in(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        chk("rstmid cpu_accept", 32'(cpu_if.accept), 32'h1);
        step();
        rst = 1'b1;
        idle();
        #4;
        chk("rstmid cpu_ack", 32'(cpu_if.ack), 32'h0);
        chk("rstmid ext_ack", 32'(ext_if.ack), 32'h0);
        step();
        rst = 1'b0;
        #4;
        chk_all_zero("post_rst");
        step();

`ifdef TCM_ARB_STARVE_GUARD_EN
        // ---------------- force_ext with EXT withdrawn ----------------
        do_reset();
        for (int c = 0; c < L; c++) begin
            set_in(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
            #4;
            chk($sformatf("drop c%0d cpu_accept", c), 32'(cpu_if.accept), 32'h1);
            step();
        end
        set_in(1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        chk("drop cpu_accept", 32'(cpu_if.accept), 32'h1);
        chk("drop ext_accept", 32'(ext_if.accept), 32'h0);
        step();
        set_in(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
        #4;
        chk("refire stall_cnt",  stall_cnt,          32'h0);
        chk("refire ext_accept", 32'(ext_if.accept), 32'h1);
        chk("refire cpu_accept", 32'(cpu_if.accept), 32'h0);
        step();
        idle();
        #4;
        chk("refire final stall_cnt", stall_cnt, 32'h1);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
